waffle_mem_arbiter: RTL and testbench

//   Shares the single-port 8-bit WAFFLE RAM and memory-mapped I/O between two masters.
//   m0 is the CPU core; m1 is the program loader/DMA port.

---
 rtl/waffle_mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_waffle_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/waffle_mem_arbiter.sv
// Round-robin arbiter for the shared WAFFLE RAM plus the LED/switch MMIO decode.
// Optional bus lock for multi-byte accesses is enabled with the WAFFLE_ARB_LOCK_EN macro.
module waffle_mem_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RAM_LIMIT = 900,
    parameter int unsigned SW_ADDR   = 998,
    parameter int unsigned LED_ADDR  = 999
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] sw,
    output logic [DATA_W-1:0] led
);

    localparam logic [ADDR_W-1:0] RAM_LIMIT_A = ADDR_W'(RAM_LIMIT);
    localparam logic [ADDR_W-1:0] SW_ADDR_A   = ADDR_W'(SW_ADDR);
    localparam logic [ADDR_W-1:0] LED_ADDR_A  = ADDR_W'(LED_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                last_r;
    logic                win_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;

    logic                grant_s;
    logic                win_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                lock_hold_s;

`ifdef WAFFLE_ARB_LOCK_EN
    logic lock_valid_r;
    logic lock_owner_r;

    assign lock_hold_s = lock_valid_r && (lock_owner_r ? m1_req : m0_req);

    // Lock tracking: armed by the winner's lock in RESP, released once the owner goes idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_valid_r <= 1'b0;
            lock_owner_r <= 1'b0;
        end else if (state_r == ST_IDLE && lock_valid_r && !lock_hold_s) begin
            lock_valid_r <= 1'b0;
        end else if (state_r == ST_RESP) begin
            lock_valid_r <= win_r ? m1_lock : m0_lock;
            lock_owner_r <= win_r;
        end
    end
`else
    logic unused_lock_s;

    assign lock_hold_s   = 1'b0;
    assign unused_lock_s = m0_lock ^ m1_lock;
`endif

    // Next-state and winner selection.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        win_s        = last_r;
        case (state_r)
            ST_IDLE: begin
                if (lock_hold_s) begin
`ifdef WAFFLE_ARB_LOCK_EN
                    grant_s = 1'b1;
                    win_s   = lock_owner_r;
`else
                    grant_s = 1'b0;
`endif
                end else if (m0_req && m1_req) begin
                    grant_s = 1'b1;
                    win_s   = ~last_r;
                end else if (m0_req) begin
                    grant_s = 1'b1;
                    win_s   = 1'b0;
                end else if (m1_req) begin
                    grant_s = 1'b1;
                    win_s   = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                state_next_s = grant_s ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Request mux for the selected master.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (win_s) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
    end

    // State register, access latch, handshake pulses, RAM port and LED register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            last_r    <= 1'b1;
            win_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            ram_addr  <= {ADDR_W{1'b0}};
            ram_we    <= 1'b0;
            ram_wdata <= {DATA_W{1'b0}};
            led       <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            ram_we    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        win_r     <= win_s;
                        last_r    <= win_s;
                        we_r      <= sel_we_s;
                        addr_r    <= sel_addr_s;
                        wdata_r   <= sel_wdata_s;
                        m0_gnt    <= ~win_s;
                        m1_gnt    <= win_s;
                        ram_addr  <= sel_addr_s;
                        ram_wdata <= sel_wdata_s;
                        // Only mapped RAM addresses ever see a write strobe; no wrap.
                        ram_we    <= sel_we_s && (sel_addr_s < RAM_LIMIT_A);
                    end
                end
                ST_ACCESS: begin
                    m0_rvalid <= ~win_r;
                    m1_rvalid <= win_r;
                    if (we_r && addr_r == LED_ADDR_A) begin
                        led <= wdata_r;
                    end
                end
                ST_RESP: begin
                    ram_we <= 1'b0;
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

    // Read-data decode, only driven while a read response is presented.
    always_comb begin
        rdata = {DATA_W{1'b0}};
        if (state_r == ST_RESP && !we_r) begin
            if (addr_r < RAM_LIMIT_A) begin
                rdata = ram_rdata;
            end else if (addr_r == SW_ADDR_A) begin
                rdata = sw;
            end else if (addr_r == LED_ADDR_A) begin
                rdata = led;
            end else begin
                rdata = {DATA_W{1'b0}};
            end
        end else begin
            rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_waffle_mem_arbiter.sv
// Bench for waffle_mem_arbiter: directed steps plus randomized rounds against a
// transaction-level model (grant order, memory image, LED value).
module tb_waffle_mem_arbiter;

`ifdef WAFFLE_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [15:0] m0_addr;
    logic [7:0]  m0_wdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [15:0] m1_addr;
    logic [7:0]  m1_wdata;
    logic [7:0]  rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  sw;
    logic [7:0]  led;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int check_cnt = 0;

    // Pending request per master, held until granted.
    logic        p_req [2];
    logic        p_we [2];
    logic [15:0] p_addr [2];
    logic [7:0]  p_wdata [2];

    // Reference model state.
    logic [7:0]  ref_mem [0:899];
    logic [7:0]  ref_led;
    int          ref_last;

    logic [7:0]  ram [0:65535] = '{default: 8'h00};

    waffle_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw(sw), .led(led)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
        m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
    endtask

    task automatic set_req(input int m, input logic we, input logic [15:0] a, input logic [7:0] d);
        p_req[m] = 1'b1; p_we[m] = we; p_addr[m] = a; p_wdata[m] = d;
    endtask

    task automatic rand_req(input int m);
        logic [15:0] a;
        case ($urandom_range(0, 6))
            0, 1:    a = 16'($urandom_range(0, 7));
            2:       a = 16'($urandom_range(896, 899));
            3:       a = 16'($urandom_range(900, 997));
            4:       a = 16'd998;
            5:       a = 16'd999;
            default: a = 16'($urandom_range(1000, 65535));
        endcase
        set_req(m, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
    endtask

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (a < 16'd900) return ref_mem[a];
        else if (a == 16'd998) return sw;
        else if (a == 16'd999) return ref_led;
        else return 8'h00;
    endfunction

    // One arbitration round, entered and left at the falling edge of an IDLE cycle.
    task automatic round(input int force_w);
        int          w;
        logic [15:0] a;
        logic        we;
        logic [7:0]  d;
        logic [7:0]  exp_rd;
        apply();
        if (!p_req[0] && !p_req[1]) begin
            @(negedge clk);
            check("idle_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
            check("idle_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            return;
        end
        if (force_w >= 0) w = force_w;
        else if (p_req[0] && p_req[1]) w = (ref_last == 1) ? 0 : 1;
        else w = p_req[1] ? 1 : 0;
        ref_last = w;
        a = p_addr[w]; we = p_we[w]; d = p_wdata[w];
        @(negedge clk);
        check("gnt", 32'({m1_gnt, m0_gnt}), (w == 1) ? 32'd2 : 32'd1);
        check("access_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        check("access_rdata", 32'(rdata), 32'd0);
        check("ram_we", 32'(ram_we), 32'(we && a < 16'd900));
        check("ram_addr", 32'(ram_addr), 32'(a));
        if (we) check("ram_wdata", 32'(ram_wdata), 32'(d));
        if (we) begin
            if (a < 16'd900) ref_mem[a] = d;
            if (a == 16'd999) ref_led = d;
            exp_rd = 8'h00;
        end else begin
            exp_rd = ref_read(a);
        end
        p_req[w] = 1'b0;
        apply();
        @(negedge clk);
        check("rvalid", 32'({m1_rvalid, m0_rvalid}), (w == 1) ? 32'd2 : 32'd1);
        check("resp_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        check("rdata", 32'(rdata), 32'(exp_rd));
        check("resp_ram_we", 32'(ram_we), 32'd0);
        check("led", 32'(led), 32'(ref_led));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 900; i++) ref_mem[i] = 8'h00;
        for (int m = 0; m < 2; m++) begin
            p_req[m] = 1'b1; p_we[m] = 1'b1; p_addr[m] = 16'h0010; p_wdata[m] = 8'hFF;
        end
        m0_lock = 1'b0; m1_lock = 1'b0; sw = 8'h00;
        rst_n = 1'b0;
        apply();

        // Reset with both masters requesting.
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        apply();
        rst_n = 1'b1;
        ref_last = 1; ref_led = 8'h00;

        // Single write then read-back.
        set_req(0, 1'b1, 16'h0010, 8'hA5); round(-1);
        set_req(0, 1'b0, 16'h0010, 8'h00); round(-1);

        // Continuous contention: alternating grants.
        for (int k = 0; k < 4; k++) begin
            for (int m = 0; m < 2; m++) if (!p_req[m]) set_req(m, 1'b0, 16'(m + 1), 8'h00);
            round(-1);
        end
        while (p_req[0] || p_req[1]) round(-1);

        // MMIO and unmapped addresses.
        set_req(1, 1'b1, 16'd999, 8'h3C); round(-1);
        sw = 8'h81;
        set_req(0, 1'b0, 16'd998, 8'h00); round(-1);
        set_req(1, 1'b0, 16'd999, 8'h00); round(-1);
        set_req(0, 1'b1, 16'd950, 8'h55); round(-1);
        set_req(1, 1'b0, 16'd950, 8'h00); round(-1);
        set_req(0, 1'b1, 16'd899, 8'h5A); round(-1);
        set_req(1, 1'b0, 16'd899, 8'h00); round(-1);

        // Randomized traffic.
        repeat (150) begin
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom_range(0, 255));
            for (int m = 0; m < 2; m++)
                if (!p_req[m] && $urandom_range(0, 3) != 0) rand_req(m);
            round(-1);
        end
        while (p_req[0] || p_req[1]) round(-1);

        // Reset during ACCESS of an m1 read aborts the response.
        set_req(1, 1'b0, 16'd3, 8'h00);
        apply();
        @(negedge clk);
        check("abort_gnt", 32'(m1_gnt), 32'd1);
        rst_n = 1'b0;
        p_req[1] = 1'b0;
        apply();
        @(negedge clk);
        check("abort_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        check("abort_led", 32'(led), 32'd0);
        rst_n = 1'b1;
        ref_last = 1; ref_led = 8'h00;
        round(-1);

        // Lock: m0 keeps the bus while locked, otherwise grants alternate.
        m0_lock = 1'b1;
        set_req(0, 1'b0, 16'd1, 8'h00);
        set_req(1, 1'b0, 16'd2, 8'h00);
        round(-1);
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) if (!p_req[m]) set_req(m, 1'b0, 16'(k + 4), 8'h00);
            round(LOCK_EN ? 0 : -1);
        end
        p_req[0] = 1'b0;
        if (!p_req[1]) set_req(1, 1'b0, 16'd7, 8'h00);
        round(-1);
        m0_lock = 1'b0;
        while (p_req[0] || p_req[1]) round(-1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
